// File: rtl/cursor_overlay_pkg.sv
// Shared text-grid geometry and cursor state type for the VGA text overlay path.
package vga_text_pkg;

  localparam int COLS        = 80;
  localparam int ROWS        = 60;
  localparam int CELL_W      = 8;
  localparam int CELL_H      = 8;
  localparam int CELL_W_LOG2 = $clog2(CELL_W);
  localparam int CELL_H_LOG2 = $clog2(CELL_H);

  typedef struct packed {
    logic       en;
    logic [7:0] row;
    logic [7:0] col;
  } cursor_state_t;

endpackage

// File: rtl/cursor_overlay_if.sv
// Cursor register / scan position inputs and overlay outputs of the text cursor overlay.
interface cursor_overlay_if #(
  parameter int XW = 10,
  parameter int YW = 10
);

  logic          c_en_i;
  logic [7:0]    c_row_i;
  logic [7:0]    c_col_i;
  logic          frame_start_i;
  logic          video_on_i;
  logic [XW-1:0] pix_x_i;
  logic [YW-1:0] pix_y_i;
  logic          cursor_on_o;
  logic          blink_phase_o;

  modport master (
    output c_en_i, c_row_i, c_col_i, frame_start_i, video_on_i, pix_x_i, pix_y_i,
    input  cursor_on_o, blink_phase_o
  );

  modport slave (
    input  c_en_i, c_row_i, c_col_i, frame_start_i, video_on_i, pix_x_i, pix_y_i,
    output cursor_on_o, blink_phase_o
  );

endinterface

// File: rtl/cursor_overlay_blink_timer.sv
// Frame-counting blink timer: phase toggles every BLINK_FRAMES ticks, restart forces visible.
module cursor_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic tick_i,
  input  logic restart_i,
  output logic phase_o
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (tick_i) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/cursor_overlay.sv
// Underline cursor overlay for the 80x60 text grid with frame-synchronous shadowing.
// Optional blinking is compiled in with CURSOR_BLINK_EN; otherwise the cursor is steady.
module cursor_overlay
  import vga_text_pkg::*;
#(
  parameter int UL_LINES     = 2,
  parameter int BLINK_FRAMES = 30,
  parameter int XW           = 10,
  parameter int YW           = 10
) (
  input logic             clk_i,
  input logic             reset_n_i,
  cursor_overlay_if.slave bus
);

  localparam logic [CELL_H_LOG2-1:0] UL_FIRST = CELL_H_LOG2'(CELL_H - UL_LINES);

  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("cursor_overlay: BLINK_FRAMES must be >= 1");
  end

  cursor_state_t          shadow_q, shadow_d;
  logic                   in_range;
  logic                   phase;
  logic                   hit;
  logic                   cursor_on_q;
  logic [XW-1:0]          cx;
  logic [YW-1:0]          cy;
  logic [CELL_H_LOG2-1:0] line;

  // Out-of-range positions are still captured so a later in-range write is seen as a move.
  assign in_range = (bus.c_row_i < 8'(ROWS)) && (bus.c_col_i < 8'(COLS));

  always_comb begin
    shadow_d.en  = bus.c_en_i & in_range;
    shadow_d.row = bus.c_row_i;
    shadow_d.col = bus.c_col_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shadow_q <= '0;
    end else if (bus.frame_start_i) begin
      shadow_q <= shadow_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  logic restart;

  assign restart = bus.frame_start_i &
                   ((shadow_d.row != shadow_q.row) |
                    (shadow_d.col != shadow_q.col) |
                    (shadow_d.en & ~shadow_q.en));

  cursor_blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .tick_i    (bus.frame_start_i),
    .restart_i (restart),
    .phase_o   (phase)
  );
`else
  assign phase = 1'b1;
`endif

  // Compared at full scan width; x < 640 keeps cx within the 8-bit column range.
  assign cx   = bus.pix_x_i >> CELL_W_LOG2;
  assign cy   = bus.pix_y_i >> CELL_H_LOG2;
  assign line = bus.pix_y_i[CELL_H_LOG2-1:0];

  assign hit = bus.video_on_i & shadow_q.en & phase &
               (cx == XW'(shadow_q.col)) &
               (cy == YW'(shadow_q.row)) &
               (line >= UL_FIRST);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cursor_on_q <= 1'b0;
    end else begin
      cursor_on_q <= hit;
    end
  end

  assign bus.cursor_on_o   = cursor_on_q;
  assign bus.blink_phase_o = phase;

endmodule

// File: tb/tb_cursor_overlay.sv
// Randomized and directed checks of cursor_overlay against a frame-level behavioural model.
module tb_cursor_overlay;

  localparam int BF  = 30;
  localparam int ULL = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cursor_overlay_if #(.XW(10), .YW(10)) bus ();

  cursor_overlay #(
    .UL_LINES     (ULL),
    .BLINK_FRAMES (BF),
    .XW           (10),
    .YW           (10)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: shadowed cursor plus frames elapsed since the last blink restart.
  int m_en, m_row, m_col, m_frames;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_phase();
`ifdef CURSOR_BLINK_EN
    return (((m_frames / BF) % 2) == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  function automatic int m_hit(input int von, input int x, input int y);
    return (von != 0 && m_en != 0 && m_phase() != 0 &&
            (x / 8) == m_col && (y / 8) == m_row && (y % 8) >= 8 - ULL) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_en = 0; m_row = 0; m_col = 0; m_frames = 0;
  endtask

  task automatic model_capture();
    int ne, nr, nc;
    bit restart;
    nr = int'(bus.c_row_i);
    nc = int'(bus.c_col_i);
    ne = (bus.c_en_i && nr < 60 && nc < 80) ? 1 : 0;
    restart = (nr != m_row) || (nc != m_col) || (ne == 1 && m_en == 0);
    if (restart) m_frames = 0;
    else         m_frames++;
    m_en = ne; m_row = nr; m_col = nc;
  endtask

  task automatic step(input bit fs, input bit von, input int x, input int y);
    int e;
    bus.frame_start_i = fs;
    bus.video_on_i    = von;
    bus.pix_x_i       = 10'(x);
    bus.pix_y_i       = 10'(y);
    e = m_hit(von, x, y);
    if (fs) model_capture();
    @(posedge clk);
    #1;
    chk("cursor_on", bus.cursor_on_o, e);
    chk("blink_phase", bus.blink_phase_o, m_phase());
    bus.frame_start_i = 1'b0;
  endtask

  task automatic set_cursor(input bit en, input int row, input int col);
    bus.c_en_i  = en;
    bus.c_row_i = 8'(row);
    bus.c_col_i = 8'(col);
  endtask

  task automatic frame();
    step(1'b1, 1'b0, 0, 0);
  endtask

  task automatic rand_pixel(output int x, output int y);
    if ($urandom_range(1, 0) == 1 && m_col < 80 && m_row < 60) begin
      x = m_col * 8 + int'($urandom_range(7, 0));
      y = m_row * 8 + int'($urandom_range(7, 0));
    end else begin
      x = int'($urandom_range(639, 0));
      y = int'($urandom_range(479, 0));
    end
  endtask

  initial begin
    int x, y;
    model_reset();
    set_cursor(1'b0, 0, 0);
    bus.frame_start_i = 1'b0;
    bus.video_on_i    = 1'b0;
    bus.pix_x_i       = '0;
    bus.pix_y_i       = '0;

    #12;
    chk("rst_cursor_on", bus.cursor_on_o, 0);
    chk("rst_blink_phase", bus.blink_phase_o, 1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Top-left cell: only lines 6..7 of x 0..7 hit.
    set_cursor(1'b1, 0, 0);
    frame();
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < 10; xx++)
        step(1'b0, 1'b1, xx, yy);

    // Bottom-right corner cell, active and blanked.
    set_cursor(1'b1, 59, 79);
    frame();
    for (int yy = 476; yy < 480; yy++)
      for (int xx = 630; xx < 640; xx++)
        step(1'b0, 1'b1, xx, yy);
    for (int yy = 478; yy < 480; yy++)
      for (int xx = 632; xx < 640; xx++)
        step(1'b0, 1'b0, xx, yy);

    // Range guard on row then on column.
    set_cursor(1'b1, 60, 5);
    frame();
    for (int i = 0; i < 100; i++) begin
      rand_pixel(x, y);
      step(1'b0, 1'b1, x, y);
    end
    for (int xx = 40; xx < 48; xx++) step(1'b0, 1'b1, xx, 479);
    set_cursor(1'b1, 3, 80);
    frame();
    for (int xx = 624; xx < 640; xx++) step(1'b0, 1'b1, xx, 31);
    for (int i = 0; i < 100; i++) begin
      rand_pixel(x, y);
      step(1'b0, 1'b1, x, y);
    end

    // Static cursor over many frames: blink in the blink build, steady otherwise.
    set_cursor(1'b1, 5, 10);
    for (int f = 0; f < 100; f++) begin
      frame();
      step(1'b0, 1'b1, 80 + int'($urandom_range(7, 0)), 46);
      step(1'b0, 1'b1, 84, 47);
    end
    // 99 frames since restart leaves the blink build in an invisible half-period.
    step(1'b0, 1'b1, 81, 47);

    // Mid-frame move is not seen until the next frame_start, which restarts the blink.
    set_cursor(1'b1, 5, 11);
    step(1'b0, 1'b1, 88, 47);
    step(1'b0, 1'b1, 80, 47);
    frame();
    step(1'b0, 1'b1, 88, 47);
    step(1'b0, 1'b1, 95, 46);
    step(1'b0, 1'b1, 80, 47);

    // Asynchronous reset while the overlay is asserted.
    step(1'b0, 1'b1, 90, 47);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_cursor_on", bus.cursor_on_o, 0);
    chk("async_rst_blink_phase", bus.blink_phase_o, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 90, 47);
    frame();
    step(1'b0, 1'b1, 90, 47);

    // Random register writes, frame starts and pixels.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(49, 0) == 0)
        set_cursor(1'($urandom_range(3, 0) != 0), int'($urandom_range(62, 0)),
                   int'($urandom_range(82, 0)));
      rand_pixel(x, y);
      step(1'($urandom_range(39, 0) == 0), 1'($urandom_range(7, 0) != 0), x, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
